// File: rtl/prio_enc_serializer.sv
// Priority-encoding serializer: accepts an N-bit request vector and emits the
// index of every set bit, one per beat, together with popcount and an empty flag.
module prio_enc_serializer #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IDX_W     = $clog2(N),
  parameter int CNT_W     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] d,
  output logic             last,
  output logic             zero,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cur_idx;
  logic             single;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // The last matching bit in the scan wins, so the scan direction is the
  // reverse of the emission order.
  function automatic logic [IDX_W-1:0] pick_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (LSB_FIRST) begin
        if (v[N-1-i]) idx = IDX_W'(N - 1 - i);
      end else begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  assign cur_idx = pick_idx(pending_q);
  assign single  = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
  assign cnt     = cnt_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    d         = '0;
    last      = 1'b0;
    zero      = 1'b0;
    in_ready  = (state_q == IDLE) & en & rst_n;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          cnt_d = popcount(a);
          if (a != '0) begin
            pending_d = a;
            state_d   = SCAN;
          end else begin
            pending_d = '0;
            state_d   = ZERO;
          end
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        d         = cur_idx;
        last      = single;
        if (out_ready) begin
          pending_d = pending_q & ~(N'(1) << cur_idx);
          if (single) state_d = IDLE;
        end
      end
      ZERO: begin
        out_valid = 1'b1;
        last      = 1'b1;
        zero      = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
